hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Interlock controller for the 5-stage pipeline, covering the hazards operand forwarding cannot resolve.
//  - Load-use: lw in D/X feeding the instruction in F/D -> hold PC and F/D, inject nop into D/X.
//  - Multi-cycle mul/div: freezes PC, F/D and D/X while the multdiv unit runs; injects nops into X/M.
//  - Sits beside the forwarding controls in decode/execute; drives latch enables and multdiv ctrl pulses.
// PARAMETERS
//  MD_TIMEOUT  64  max BUSY cycles before forced release (>=2)
//  CNT_W       7   width of BUSY cycle counter; 2^CNT_W > MD_TIMEOUT
// PORTS
//  clock           in   1   rising-edge clock
//  reset           in   1   synchronous, active-low reset
//  FD_IR           in   32  instruction in F/D latch
//  DX_IR           in   32  instruction in D/X latch
//  multdiv_ready   in   1   multdiv result valid (1-cycle pulse)
//  ctrl_MULT       out  1   1-cycle multiply start pulse
//  ctrl_DIV        out  1   1-cycle divide start pulse
//  stall_FD        out  1   1: hold PC and F/D latch (load-use)
//  bubble_DX       out  1   1: write nop into D/X (load-use)
//  freeze_front    out  1   1: hold PC, F/D, D/X (multdiv in flight)
//  bubble_XM       out  1   1: write nop into X/M
//  md_done         out  1   1: multdiv result to X/M this cycle
//  md_timeout      out  1   1: md_done forced by timeout
//  stall_cycles    out  32  load-use stall count (HAZARD_PERF_EN)
//  md_cycles       out  32  freeze cycle count (HAZARD_PERF_EN)
// BEHAVIOUR
//  Fields: op=[31:27] rd=[26:22] rs=[21:17] rt=[16:12] aluop=[6:2].
//  mul = op 00000 & aluop 00110; div = op 00000 & aluop 00111. lw = op 01000.
//  FD source regs: R-type(00000) rs,rt; addi(00101)/lw rs; sw(00111) rs only; bne(00010)/blt(00110)/jr(00100) rd,rs;
//   bex(10110) r30; j/jal/setx none. sw data reg (rd) excluded: lw->sw data forwarded in M.
//  Load-use (comb.): lw in DX, DX.rd!=0, DX.rd equals any FD source -> stall_FD=bubble_DX=1.
//  FSM states IDLE, BUSY; 1 state reg, CNT_W counter.
//   IDLE: DX mul/div -> ctrl_MULT/ctrl_DIV=1, freeze_front=1, bubble_XM=1, cnt<=0, ->BUSY.
//   BUSY: freeze_front=bubble_XM=1, cnt++. multdiv_ready -> md_done=1, freeze_front=bubble_XM=0, ->IDLE.
//   BUSY, cnt==MD_TIMEOUT-1, no ready -> md_done=md_timeout=1, release as above, ->IDLE.
//  Latency: N-cycle multdiv (ready N cycles after start) -> freeze_front high N cycles; start cycle included.
//  Back-to-back mul: next mul enters DX on release cycle -> starts next cycle from IDLE; no idle gap beyond it.
//  Priority: freeze_front=1 masks stall_FD, bubble_DX to 0.
//  multdiv_ready in IDLE ignored; start pulses never issued in BUSY.
//  Reset (low at edge): state<=IDLE, cnt<=0; every output 0 after that edge, incl. mid-BUSY.
//  While reset low, comb. outputs forced 0.
// CONFIGURATION
//  HAZARD_PERF_EN defined: stall_cycles +1 per cycle with stall_FD=1; md_cycles +1 per cycle freeze_front=1.
//   Both reset to 0; saturate at 32'hFFFFFFFF (no wrap).
//  Undefined: no counter flops; stall_cycles, md_cycles tied to 32'd0.
// TESTING
//  DX=lw r5; FD=add r6,r5,r2 -> stall_FD=1, bubble_DX=1 that cycle; 0 once DX=nop.
//  DX=lw r0; FD=add r6,r0,r0 -> no stall. DX=lw r5; FD=sw r5,0(r7) -> no stall; FD=sw r7,0(r5) -> stall.
//  DX=mul; ready 17 cycles after start -> ctrl_MULT 1 cycle; freeze_front 17 cycles; md_done with ready.
//  mul then div back-to-back -> ctrl_DIV in cycle after mul's md_done; freeze gap of exactly 1 cycle.
//  ready never arrives, MD_TIMEOUT=64 -> md_done=md_timeout=1 in 64th BUSY cycle; state IDLE next.
//  reset low in 5th BUSY cycle -> all outputs 0 next cycle; later ready ignored; perf counters 0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: load-use stall/bubble plus multdiv freeze with timeout release.
// Latency: load-use is combinational; an N-cycle multdiv freezes the front end for N cycles.
// Backpressure: holds PC/F/D (and D/X while multdiv runs); perf counters only with HAZARD_PERF_EN.
module hazard_stall_unit #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] FD_IR,
    input  logic [31:0] DX_IR,
    input  logic        multdiv_ready,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall_FD,
    output logic        bubble_DX,
    output logic        freeze_front,
    output logic        bubble_XM,
    output logic        md_done,
    output logic        md_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] md_cycles
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] REG_STATUS = 5'd30;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdState_e;

    mdState_e         state;
    mdState_e         nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nextCnt;

    logic [4:0] fdOp, fdRd, fdRs, fdRt;
    logic [4:0] dxOp, dxRd, dxAluop;
    logic       dxIsLw, dxIsMul, dxIsDiv, mdStart;
    logic       fdReadsRs, fdReadsRt, fdReadsRd, fdReadsStatus;
    logic       loadUse;
    logic       unusedBits;

    assign fdOp    = FD_IR[31:27];
    assign fdRd    = FD_IR[26:22];
    assign fdRs    = FD_IR[21:17];
    assign fdRt    = FD_IR[16:12];
    assign dxOp    = DX_IR[31:27];
    assign dxRd    = DX_IR[26:22];
    assign dxAluop = DX_IR[6:2];
    assign unusedBits = ^{FD_IR[11:0], DX_IR[21:7], DX_IR[1:0]};

    assign dxIsLw  = (dxOp == OP_LW);
    assign dxIsMul = (dxOp == OP_RTYPE) && (dxAluop == ALU_MUL);
    assign dxIsDiv = (dxOp == OP_RTYPE) && (dxAluop == ALU_DIV);
    assign mdStart = dxIsMul || dxIsDiv;

    // sw's data register is forwarded in M, so only its base register counts
    always_comb begin
        fdReadsRs     = 1'b0;
        fdReadsRt     = 1'b0;
        fdReadsRd     = 1'b0;
        fdReadsStatus = 1'b0;
        case (fdOp)
            OP_RTYPE: begin
                fdReadsRs = 1'b1;
                fdReadsRt = 1'b1;
            end
            OP_ADDI, OP_LW, OP_SW: fdReadsRs = 1'b1;
            OP_BNE, OP_BLT, OP_JR: begin
                fdReadsRd = 1'b1;
                fdReadsRs = 1'b1;
            end
            OP_BEX:  fdReadsStatus = 1'b1;
            default: ;
        endcase
    end

    assign loadUse = dxIsLw && (dxRd != 5'd0) &&
                     ((fdReadsRs && (fdRs == dxRd)) ||
                      (fdReadsRt && (fdRt == dxRd)) ||
                      (fdReadsRd && (fdRd == dxRd)) ||
                      (fdReadsStatus && (dxRd == REG_STATUS)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        case (state)
            IDLE: begin
                if (mdStart) begin
                    nextState = BUSY;
                    nextCnt   = '0;
                end
            end
            BUSY: begin
                nextCnt = cnt + CNT_W'(1);
                if (multdiv_ready || (cnt == CNT_LAST)) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // A real ready wins over a coincident timeout, so md_timeout stays low then
    always_comb begin
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        freeze_front = 1'b0;
        bubble_XM    = 1'b0;
        md_done      = 1'b0;
        md_timeout   = 1'b0;
        stall_FD     = 1'b0;
        bubble_DX    = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (mdStart) begin
                        ctrl_MULT    = dxIsMul;
                        ctrl_DIV     = dxIsDiv;
                        freeze_front = 1'b1;
                        bubble_XM    = 1'b1;
                    end
                end
                BUSY: begin
                    if (multdiv_ready) begin
                        md_done = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        md_done    = 1'b1;
                        md_timeout = 1'b1;
                    end else begin
                        freeze_front = 1'b1;
                        bubble_XM    = 1'b1;
                    end
                end
                default: ;
            endcase
            stall_FD  = loadUse && !freeze_front;
            bubble_DX = loadUse && !freeze_front;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt;
    logic [31:0] mdCnt;

    // Saturate rather than wrap so long runs never read back as small counts
    always_ff @(posedge clock) begin
        if (!reset) begin
            stallCnt <= 32'd0;
            mdCnt    <= 32'd0;
        end else begin
            if (stall_FD && (stallCnt != 32'hFFFF_FFFF)) begin
                stallCnt <= stallCnt + 32'd1;
            end
            if (freeze_front && (mdCnt != 32'hFFFF_FFFF)) begin
                mdCnt <= mdCnt + 32'd1;
            end
        end
    end

    assign stall_cycles = stallCnt;
    assign md_cycles    = mdCnt;
`else
    assign stall_cycles = 32'd0;
    assign md_cycles    = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: load-use vector table, multdiv sequences, random stimulus vs reference model.
// Latency: one vector per clock; Backpressure: none, the bench drives instruction latches directly.
module tb_hazard_stall_unit;

    logic        clock;
    logic        reset;
    logic [31:0] FD_IR;
    logic [31:0] DX_IR;
    logic        multdiv_ready;
    logic        ctrl_MULT, ctrl_DIV, stall_FD, bubble_DX;
    logic        freeze_front, bubble_XM, md_done, md_timeout;
    logic [31:0] stall_cycles, md_cycles;

    int   checks = 0;
    int   failures = 0;
    int   modelStall = 0;
    int   modelMd = 0;
    logic rstVal;

    logic [7:0] outVec;
    assign outVec = {ctrl_MULT, ctrl_DIV, freeze_front, bubble_XM,
                     md_done, md_timeout, stall_FD, bubble_DX};

    hazard_stall_unit #(.MD_TIMEOUT(64), .CNT_W(7)) dut (
        .clock        (clock),
        .reset        (reset),
        .FD_IR        (FD_IR),
        .DX_IR        (DX_IR),
        .multdiv_ready(multdiv_ready),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .stall_FD     (stall_FD),
        .bubble_DX    (bubble_DX),
        .freeze_front (freeze_front),
        .bubble_XM    (bubble_XM),
        .md_done      (md_done),
        .md_timeout   (md_timeout),
        .stall_cycles (stall_cycles),
        .md_cycles    (md_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rType(input logic [4:0] rd, rs, rt, aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] iType(input logic [4:0] op, rd, rs);
        return {op, rd, rs, 17'd0};
    endfunction

    // Set of architectural registers an F/D instruction reads as a hazard source
    function automatic logic [31:0] readSet(input logic [31:0] ir);
        logic [31:0] s;
        s = '0;
        case (ir[31:27])
            5'b00000: begin s[ir[21:17]] = 1'b1; s[ir[16:12]] = 1'b1; end
            5'b00101, 5'b01000, 5'b00111: s[ir[21:17]] = 1'b1;
            5'b00010, 5'b00110, 5'b00100: begin s[ir[26:22]] = 1'b1; s[ir[21:17]] = 1'b1; end
            5'b10110: s[30] = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic refStall(input logic [31:0] fd, input logic [31:0] dx);
        logic [31:0] s;
        s = readSet(fd);
        return (dx[31:27] == 5'b01000) && (dx[26:22] != 5'd0) && s[dx[26:22]];
    endfunction

    function automatic logic [4:0] pickReg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd3;
            default: return 5'd30;
        endcase
    endfunction

    task automatic cyc(input logic [31:0] fd, input logic [31:0] dx, input logic rdy);
        @(posedge clock);
        #1;
        reset = rstVal;
        FD_IR = fd;
        DX_IR = dx;
        multdiv_ready = rdy;
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkPerf(input string name);
`ifdef HAZARD_PERF_EN
        chk({name, "_stall_cycles"}, stall_cycles, modelStall);
        chk({name, "_md_cycles"}, md_cycles, modelMd);
`else
        chk({name, "_stall_cycles"}, stall_cycles, 32'd0);
        chk({name, "_md_cycles"}, md_cycles, 32'd0);
`endif
    endtask

    // Multdiv taking lat cycles from start to ready; ready past 64 cycles means timeout
    task automatic runMd(input logic isDiv, input int lat);
        logic [31:0] ir;
        int          eff;
        logic        to;
        ir  = rType(5'd3, 5'd1, 5'd2, isDiv ? 5'b00111 : 5'b00110);
        eff = (lat > 64) ? 64 : lat;
        to  = (lat > 64);
        cyc(32'd0, ir, 1'b0);
        chk($sformatf("md_start_lat%0d", lat), outVec, {~isDiv, isDiv, 6'b110000});
        for (int k = 1; k <= eff; k++) begin
            cyc(32'd0, ir, k == lat);
            if (k < eff) chk($sformatf("md_busy_lat%0d_c%0d", lat, k), outVec, 8'b0011_0000);
            else         chk($sformatf("md_release_lat%0d", lat), outVec, {4'b0000, 1'b1, to, 2'b00});
        end
        modelMd += eff;
    endtask

    typedef struct {
        logic [31:0] fd;
        logic [31:0] dx;
        logic        exp;
    } luVec_t;

    luVec_t      vecs[16];
    logic [4:0]  opList[12];
    logic [31:0] rfd, rdx;
    logic        e;

    initial begin
        rstVal = 1'b0;
        reset = 1'b0;
        FD_IR = 32'd0;
        DX_IR = 32'd0;
        multdiv_ready = 1'b0;

        vecs[0]  = '{rType(6, 5, 2, 0), iType(5'b01000, 5, 0), 1'b1};
        vecs[1]  = '{rType(6, 5, 2, 0), 32'd0, 1'b0};
        vecs[2]  = '{rType(6, 0, 0, 0), iType(5'b01000, 0, 0), 1'b0};
        vecs[3]  = '{iType(5'b00111, 5, 7), iType(5'b01000, 5, 0), 1'b0};
        vecs[4]  = '{iType(5'b00111, 7, 5), iType(5'b01000, 5, 0), 1'b1};
        vecs[5]  = '{rType(6, 2, 5, 0), iType(5'b01000, 5, 1), 1'b1};
        vecs[6]  = '{iType(5'b00101, 6, 5), iType(5'b01000, 5, 0), 1'b1};
        vecs[7]  = '{iType(5'b00101, 5, 2), iType(5'b01000, 5, 0), 1'b0};
        vecs[8]  = '{iType(5'b00010, 5, 2), iType(5'b01000, 5, 0), 1'b1};
        vecs[9]  = '{iType(5'b00100, 5, 0), iType(5'b01000, 5, 0), 1'b1};
        vecs[10] = '{iType(5'b10110, 0, 0), iType(5'b01000, 30, 0), 1'b1};
        vecs[11] = '{iType(5'b00001, 30, 30), iType(5'b01000, 30, 0), 1'b0};
        vecs[12] = '{rType(6, 5, 5, 0), rType(5, 1, 2, 0), 1'b0};
        vecs[13] = '{iType(5'b00110, 2, 5), iType(5'b01000, 5, 0), 1'b1};
        vecs[14] = '{iType(5'b10101, 5, 5), iType(5'b01000, 5, 0), 1'b0};
        vecs[15] = '{iType(5'b00011, 5, 5), iType(5'b01000, 5, 0), 1'b0};
        opList = '{5'b00000, 5'b00101, 5'b01000, 5'b00111, 5'b00010, 5'b00110,
                   5'b00100, 5'b10110, 5'b00001, 5'b00011, 5'b10101, 5'b01001};

        // Outputs are forced low while reset is held, even with hazards present
        cyc(vecs[0].fd, vecs[0].dx, 1'b0);
        chk("reset_loaduse_masked", outVec, 8'h00);
        cyc(32'd0, rType(3, 1, 2, 5'b00110), 1'b0);
        chk("reset_mul_masked", outVec, 8'h00);
        rstVal = 1'b1;
        cyc(32'd0, 32'd0, 1'b0);
        chk("post_reset_idle", outVec, 8'h00);
        chkPerf("post_reset");

        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].fd, vecs[i].dx, 1'b0);
            chk($sformatf("lu_vec%0d", i), outVec, {6'b0, vecs[i].exp, vecs[i].exp});
            if (vecs[i].exp) modelStall++;
        end

        cyc(32'd0, 32'd0, 1'b1);
        chk("ready_in_idle_ignored", outVec, 8'h00);
        chkPerf("after_table");

        runMd(1'b0, 17);
        cyc(32'd0, 32'd0, 1'b0);
        chk("after_mul17_idle", outVec, 8'h00);
        chkPerf("after_mul17");

        runMd(1'b0, 5);
        runMd(1'b1, 4);
        cyc(32'd0, 32'd0, 1'b0);
        chk("after_b2b_idle", outVec, 8'h00);

        runMd(1'b0, 1000);
        cyc(32'd0, 32'd0, 1'b0);
        chk("after_timeout_idle", outVec, 8'h00);
        runMd(1'b1, 64);
        runMd(1'b0, 1);

        for (int n = 0; n < 16; n++) begin
            runMd(1'($urandom_range(0, 1)), $urandom_range(1, 80));
        end
        cyc(32'd0, 32'd0, 1'b0);
        chk("after_random_md_idle", outVec, 8'h00);
        chkPerf("after_random_md");

        for (int n = 0; n < 300; n++) begin
            rfd = $urandom;
            rfd[31:27] = opList[$urandom_range(0, 11)];
            rfd[26:22] = pickReg();
            rfd[21:17] = pickReg();
            rfd[16:12] = pickReg();
            rdx = $urandom;
            if ($urandom_range(0, 2) != 0) rdx[31:27] = 5'b01000;
            else                           rdx[31:27] = 5'($urandom_range(1, 31));
            rdx[26:22] = pickReg();
            e = refStall(rfd, rdx);
            cyc(rfd, rdx, 1'($urandom_range(0, 1)));
            chk($sformatf("rand_lu%0d", n), outVec, {6'b0, e, e});
            if (e) modelStall++;
        end
        cyc(32'd0, 32'd0, 1'b0);
        chkPerf("after_random_lu");

        // Reset pulled low in the fifth BUSY cycle of a long multiply
        cyc(32'd0, rType(3, 1, 2, 5'b00110), 1'b0);
        chk("rst_seq_start", outVec, 8'b1011_0000);
        for (int k = 1; k <= 4; k++) begin
            cyc(32'd0, rType(3, 1, 2, 5'b00110), 1'b0);
            chk($sformatf("rst_seq_busy%0d", k), outVec, 8'b0011_0000);
        end
        rstVal = 1'b0;
        cyc(32'd0, rType(3, 1, 2, 5'b00110), 1'b0);
        chk("rst_seq_during_reset", outVec, 8'h00);
        modelStall = 0;
        modelMd = 0;
        rstVal = 1'b1;
        cyc(32'd0, 32'd0, 1'b1);
        chk("rst_seq_late_ready", outVec, 8'h00);
        chkPerf("rst_seq");
        cyc(32'd0, 32'd0, 1'b0);
        chk("rst_seq_idle", outVec, 8'h00);
        runMd(1'b1, 3);
        cyc(32'd0, 32'd0, 1'b0);
        chkPerf("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
